// File: rtl/mem_writeback_sequencer.sv
// Copies 1..16 consecutive data-memory words into the register file write port on a memtoreg load.
// Latency: READ_LAT+1 cycles per word; done pulses one cycle after the last write.
// No backpressure: start is ignored while a transfer runs; WB_REG0_PROTECT_EN suppresses writes to r0.
module mem_writeback_sequencer #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int READ_LAT = 1
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              start,
   input  logic              memtoreg,
   input  logic              abort,
   input  logic [ADDR_W-1:0] mem_base,
   input  logic [ADDR_W-1:0] reg_base,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] reg_wdata,
   output logic [ADDR_W-1:0] reg_waddr,
   output logic              reg_load,
   output logic              busy,
   output logic              done
);

   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, WRITE, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] mem_addr, reg_addr, len_q, word_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic              lat_last, accept, capture, advance;

   assign lat_last  = (lat_cnt == LAT_W'(READ_LAT - 1));
   assign mem_raddr = mem_addr;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
      reg_load  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start && memtoreg) begin
               accept    = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else if (lat_last) begin
               capture   = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            busy    = 1'b1;
            advance = 1'b1;
`ifdef WB_REG0_PROTECT_EN
            reg_load = (reg_waddr != '0);
`else
            reg_load = 1'b1;
`endif
            // an abort here lets the write already on the port finish
            if (abort)                  state_nxt = IDLE;
            else if (word_cnt == len_q) state_nxt = DONE;
            else                        state_nxt = ADDR;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         mem_addr  <= '0;
         reg_addr  <= '0;
         len_q     <= '0;
         word_cnt  <= '0;
         lat_cnt   <= '0;
         reg_wdata <= '0;
         reg_waddr <= '0;
      end else begin
         if (accept) begin
            mem_addr <= mem_base;
            reg_addr <= reg_base;
            len_q    <= len;
            word_cnt <= '0;
         end
         // counts only while lingering in ADDR waiting for read data
         if (state == ADDR && state_nxt == ADDR) lat_cnt <= lat_cnt + LAT_W'(1);
         else                                    lat_cnt <= '0;
         if (capture) begin
            reg_wdata <= mem_rdata;
            reg_waddr <= reg_addr;
         end
         if (advance) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            reg_addr <= reg_addr + ADDR_W'(1);
            word_cnt <= word_cnt + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_writeback_sequencer.sv
// Randomized bench for mem_writeback_sequencer: a transfer-level model predicts every
// register write (cycle, address, data) and done pulse; a negedge monitor scores them.
module tb_mem_writeback_sequencer;

   localparam int L = 1;
   localparam int P = L + 1;

   logic        clock = 1'b0;
   logic        clear_n, start, memtoreg, abort;
   logic [3:0]  mem_base, reg_base, len, mem_raddr, reg_waddr;
   logic [15:0] mem_rdata, reg_wdata;
   logic        reg_load, busy, done;

   logic [15:0] mem [16];
   int          cyc = 0;
   int          n_pass = 0, n_total = 0;

   typedef struct {
      int          c;
      logic [3:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t wr_q[$];
   int  done_q[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   assign mem_rdata = mem[mem_raddr];

   mem_writeback_sequencer #(.DATA_W(16), .ADDR_W(4), .READ_LAT(L)) dut (
      .clock(clock), .clear_n(clear_n), .start(start), .memtoreg(memtoreg), .abort(abort),
      .mem_base(mem_base), .reg_base(reg_base), .len(len), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .reg_wdata(reg_wdata), .reg_waddr(reg_waddr),
      .reg_load(reg_load), .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // scoreboard monitor: every write and done pulse must match the head of its queue
   always @(negedge clock) begin
      wr_t e;
      int  dc;
      if (clear_n === 1'b1) begin
         if (reg_load !== 1'b0) begin
            if (wr_q.size() == 0) begin
               check("unexpected_load", 64'(reg_load), 64'(0));
            end else begin
               e = wr_q.pop_front();
               check("write", {32'(cyc), 12'h0, reg_waddr, reg_wdata}, {32'(e.c), 12'h0, e.a, e.d});
            end
         end
         if (done !== 1'b0) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'(0));
            end else begin
               dc = done_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(dc));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         start    = 1'b0;
         abort    = 1'b0;
         memtoreg = 1'($urandom_range(1));
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, {mem_raddr, reg_wdata, reg_waddr, reg_load, busy, done}, '0);
   endtask

   task automatic push_write(input int c, input logic [3:0] a, input logic [15:0] d);
      wr_t e;
      e.c = c; e.a = a; e.d = d;
`ifdef WB_REG0_PROTECT_EN
      if (a != 4'd0) wr_q.push_back(e);
`else
      wr_q.push_back(e);
`endif
   endtask

   // abort_at <= 0: no abort; otherwise abort held high during that relative cycle
   task automatic xfer(input logic [3:0] mb, input logic [3:0] rb, input logic [3:0] ln,
                       input int abort_at, input int junk_pct);
      int         n, last, endc, c0;
      logic [3:0] ea;
      n = int'(ln) + 1;
      tick();
      c0 = cyc;
      start = 1'b1; memtoreg = 1'b1; abort = 1'b0;
      mem_base = mb; reg_base = rb; len = ln;
      last = (abort_at > 0) ? abort_at : n * P;
      endc = (abort_at > 0) ? abort_at : n * P + 1;
      for (int i = 0; i < n; i++)
         if (abort_at <= 0 || (i + 1) * P <= abort_at)
            push_write(c0 + (i + 1) * P, rb + 4'(i), mem[mb + 4'(i)]);
      if (abort_at <= 0) done_q.push_back(c0 + n * P + 1);
      for (int r = 1; r <= endc; r++) begin
         tick();
         abort    = (r == abort_at);
         start    = ($urandom_range(99) < junk_pct);
         memtoreg = 1'($urandom_range(1));
         mem_base = 4'($urandom); reg_base = 4'($urandom); len = 4'($urandom);
         check("busy", 64'(busy), 64'(r <= last));
         if (r <= last && (r % P) != 0) begin
            ea = mb + 4'(r / P);
            check("mem_raddr", 64'(mem_raddr), 64'(ea));
         end
      end
   endtask

   initial begin
      int         c0, ab, nw;
      logic [3:0] mb, rb, ln;
      clear_n = 1'b0; start = 1'b0; memtoreg = 1'b0; abort = 1'b0;
      mem_base = '0; reg_base = '0; len = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      repeat (3) tick();
      check_all_zero("reset_outputs");
      clear_n = 1'b1;
      idle(2);

      // single word
      mem[7] = 16'h4BC5;
      xfer(4'd7, 4'd3, 4'd0, -1, 0);
      idle(1);

      // four words wrapping both address spaces
      mem[14] = 16'h00A1; mem[15] = 16'h00A2; mem[0] = 16'h00A3; mem[1] = 16'h00A4;
      xfer(4'd14, 4'd14, 4'd3, -1, 30);
      idle(2);

      // start without memtoreg is ignored
      tick();
      start = 1'b1; memtoreg = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         start = 1'($urandom_range(1)); memtoreg = 1'b0;
         check("busy_no_memtoreg", 64'(busy), 64'(0));
      end
      idle(1);

      // abort in the second ADDR, then an immediate restart
      xfer(4'($urandom), 4'($urandom), 4'd5, P + 1, 0);
      xfer(4'($urandom), 4'($urandom), 4'd2, -1, 20);
      idle(1);

      // abort during the last WRITE: write lands, no done
      xfer(4'd3, 4'd9, 4'd1, 2 * P, 0);
      idle(1);

      // reset during the WRITE of the second word of a 3-word burst
      mb = 4'($urandom); rb = 4'($urandom);
      tick();
      c0 = cyc;
      start = 1'b1; memtoreg = 1'b1; mem_base = mb; reg_base = rb; len = 4'd2;
      push_write(c0 + P, rb, mem[mb]);
      for (int r = 1; r <= 2 * P; r++) begin
         tick();
         start = 1'b0;
         if (r == 2 * P) clear_n = 1'b0;
      end
      tick();
      clear_n = 1'b1;
      check_all_zero("reset_cut");
      idle(4);
      xfer(mb, rb, 4'd2, -1, 0);
      idle(1);

      // destination starting at r0
      xfer(4'($urandom), 4'd0, 4'd1, -1, 0);
      idle(1);

      // randomized transfers with aborts and junk starts
      for (int t = 0; t < 40; t++) begin
         mem[$urandom_range(15)] = 16'($urandom);
         mb = 4'($urandom); rb = 4'($urandom); ln = 4'($urandom);
         nw = int'(ln) + 1;
         ab = ($urandom_range(3) == 0) ? int'($urandom_range(nw * P, 1)) : -1;
         xfer(mb, rb, ln, ab, 25);
         idle($urandom_range(2));
      end

      idle(6);
      check("writes_drained", 64'(wr_q.size()), 64'(0));
      check("dones_drained", 64'(done_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
